// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD divider: digit width, the all-nines digit,
// the divider state encoding and a BCD digit validity helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } bcd_div_state_t;

  // True when the nibble encodes a decimal digit 0..9.
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_div_chk.sv
// Checker for the BCD divider: a quotient digit counter must never reach ten.
module bcd_div_chk (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic [3:0] i_cnt
);

  a_cnt_le_nine: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_cnt <= 4'd9)
    else $error("bcd_div: quotient digit counter reached %0d", i_cnt);

endmodule

// File: rtl/bcd_sub_n.sv
// Combinational N-digit ripple BCD subtractor: o_d = i_a - i_b - i_bin,
// with the borrow out of the most significant digit on o_bout.
module bcd_sub_n
  import bcd_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [DIGIT_W*N-1:0] i_a,
  input  logic [DIGIT_W*N-1:0] i_b,
  input  logic                 i_bin,
  output logic [DIGIT_W*N-1:0] o_d,
  output logic                 o_bout
);

  logic [N:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar k = 0; k < N; k++) begin : g_dig
    logic [4:0] w_diff;
    // A negative 5-bit difference means this digit borrows; adding ten
    // (mod 16) brings the result back into the 0..9 range.
    assign w_diff = {1'b0, i_a[k*DIGIT_W +: DIGIT_W]}
                  - {1'b0, i_b[k*DIGIT_W +: DIGIT_W]}
                  - {4'b0000, w_borrow[k]};
    assign w_borrow[k+1] = w_diff[4];
    assign o_d[k*DIGIT_W +: DIGIT_W] = w_diff[4] ? (w_diff[3:0] + 4'd10) : w_diff[3:0];
  end

  assign o_bout = w_borrow[N];

endmodule

// File: rtl/bcd_div.sv
// Sequential packed-BCD divider (digit-serial restoring division).
// Optional feature macro: BCD_DIV_DIGIT_CHK_EN enables the invalid-digit check
// at load (err_o); without it err_o stays 0.
module bcd_div
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ld_i,
  input  logic [DIGIT_W*DIGITS-1:0] a_i,
  input  logic [DIGIT_W*DIGITS-1:0] b_i,
  output logic [DIGIT_W*DIGITS-1:0] q_o,
  output logic [DIGIT_W*DIGITS-1:0] r_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      dbz_o,
  output logic                      err_o
);

  localparam int W   = DIGIT_W * DIGITS;
  localparam int RW  = W + DIGIT_W;
  localparam int DCW = $clog2(DIGITS + 1);

  bcd_div_state_t r_state, w_state_nxt;

  logic [W-1:0]   r_a, r_b, r_q, r_q_o, r_r_o;
  logic [RW-1:0]  r_r;
  logic [3:0]     r_cnt;
  logic [DCW-1:0] r_dcnt;
  logic           r_fast, r_done, r_busy, r_dbz, r_err;

  logic [RW-1:0]  w_d;
  logic           w_bout, w_b_zero, w_bad, w_last;
  logic [W-1:0]   w_q_shift;

  assign w_b_zero  = (b_i == {W{1'b0}});
  assign w_last    = (r_dcnt == DCW'(DIGITS - 1));
  assign w_q_shift = {r_q[W-DIGIT_W-1:0], r_cnt};

`ifdef BCD_DIV_DIGIT_CHK_EN
  // Flag any non-decimal nibble in either operand at load time.
  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd_digit(a_i[k*DIGIT_W +: DIGIT_W]) || !is_bcd_digit(b_i[k*DIGIT_W +: DIGIT_W])) begin
        w_bad = 1'b1;
      end else begin
        w_bad = w_bad;
      end
    end
  end
`else
  assign w_bad = 1'b0;
`endif

  // Trial subtraction of the divisor from the partial remainder.
  bcd_sub_n #(.N(DIGITS + 1)) u_sub (
    .i_a   (r_r),
    .i_b   ({{DIGIT_W{1'b0}}, r_b}),
    .i_bin (1'b0),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  bcd_div_chk u_chk (
    .i_clk  (clk_i),
    .i_rst_n(rst_ni),
    .i_cnt  (r_cnt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; divide-by-zero and bad digits skip straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ld_i) begin
          if (w_bad || w_b_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SHIFT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: w_state_nxt = SUB;
      SUB: begin
        if (w_bout && w_last) begin
          w_state_nxt = DONE;
        end else if (w_bout) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = SUB;
        end
      end
      DONE: begin
        // Early-exit cases spend one extra cycle here so their strobe lands
        // after the second edge.
        if (r_fast) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a    <= {W{1'b0}};
      r_b    <= {W{1'b0}};
      r_r    <= {RW{1'b0}};
      r_q    <= {W{1'b0}};
      r_cnt  <= 4'd0;
      r_dcnt <= {DCW{1'b0}};
      r_fast <= 1'b0;
      r_q_o  <= {W{1'b0}};
      r_r_o  <= {W{1'b0}};
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_dbz  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (ld_i) begin
            r_a    <= a_i;
            r_b    <= b_i;
            r_r    <= {RW{1'b0}};
            r_q    <= {W{1'b0}};
            r_cnt  <= 4'd0;
            r_dcnt <= {DCW{1'b0}};
            r_dbz  <= 1'b0;
            r_err  <= 1'b0;
            if (w_bad) begin
              r_err  <= 1'b1;
              r_q_o  <= {W{1'b0}};
              r_r_o  <= {W{1'b0}};
              r_fast <= 1'b1;
            end else if (w_b_zero) begin
              r_dbz  <= 1'b1;
              r_q_o  <= {DIGITS{BCD_NINE}};
              r_r_o  <= a_i;
              r_fast <= 1'b1;
            end else begin
              r_fast <= 1'b0;
            end
          end
        end
        SHIFT: begin
          r_r <= {r_r[W-1:0], r_a[W-1 -: DIGIT_W]};
          r_a <= {r_a[W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
        end
        SUB: begin
          if (!w_bout) begin
            r_r   <= w_d;
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_q    <= w_q_shift;
            r_cnt  <= 4'd0;
            r_dcnt <= r_dcnt + DCW'(1);
            if (w_last) begin
              r_q_o  <= w_q_shift;
              r_r_o  <= r_r[W-1:0];
              r_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (r_fast) begin
            r_fast <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: r_fast <= 1'b0;
      endcase
    end
  end

  assign q_o    = r_q_o;
  assign r_o    = r_r_o;
  assign done_o = r_done;
  assign busy_o = r_busy;
  assign dbz_o  = r_dbz;
  assign err_o  = r_err;

endmodule

// File: tb/tb_bcd_div.sv
// Scoreboard bench for bcd_div: stimulus pushes expected results computed with
// integer arithmetic; a monitor pops and compares on every done_o strobe.
module tb_bcd_div;

  localparam int W = 16;

`ifdef BCD_DIV_DIGIT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         ld_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic [W-1:0] q_o, r_o;
  logic         done_o, busy_o, dbz_o, err_o;

  bcd_div #(.DIGITS(4)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ld_i  (ld_i),
    .a_i   (a_i),
    .b_i   (b_i),
    .q_o   (q_o),
    .r_o   (r_o),
    .done_o(done_o),
    .busy_o(busy_o),
    .dbz_o (dbz_o),
    .err_o (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         err;
    int           edge_n;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int res = 0;
    for (int k = 3; k >= 0; k--) res = res * 10 + int'(v[k*4 +: 4]);
    return res;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] res = '0;
    int t = v;
    for (int k = 0; k < 4; k++) begin
      res[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  // Reference: plain integer division; latency is two cycles per quotient
  // digit plus one per successful subtraction (the digit value).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int ld_edge);
    exp_t e;
    int ai, bi, qi, lat, t;
    bit bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (a[k*4 +: 4] > 4'd9 || b[k*4 +: 4] > 4'd9) bad = 1'b1;
    end
    ai = bcd2int(a);
    bi = bcd2int(b);
    e.dbz = 1'b0;
    e.err = 1'b0;
    if (CHK && bad) begin
      e.err = 1'b1; e.q = '0; e.r = '0; e.edge_n = ld_edge + 1;
    end else if (bi == 0) begin
      e.dbz = 1'b1; e.q = 16'h9999; e.r = a; e.edge_n = ld_edge + 1;
    end else begin
      qi = ai / bi;
      e.q = int2bcd(qi);
      e.r = int2bcd(ai % bi);
      lat = 0;
      t = qi;
      for (int k = 0; k < 4; k++) begin
        lat += (t % 10) + 2;
        t = t / 10;
      end
      e.edge_n = ld_edge + lat;
    end
    return e;
  endfunction

  // Monitor: every done strobe must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && done_o) begin
        n_done++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: strobe at edge %0d with no outstanding request", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", q_o, e.q);
          check("remainder", r_o, e.r);
          check("dbz", dbz_o, e.dbz);
          check("err", err_o, e.err);
          check("done_edge", cyc, e.edge_n);
        end
      end
    end
  end

  // Issue one division; caller must be at a negedge. Returns at the negedge
  // after the strobe so the next load lands one cycle after done_o.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    bit busy_bad;
    a_i = a;
    b_i = b;
    ld_i = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk_i);
    ld_i = 1'b0;
    busy_bad = 1'b0;
    t = 0;
    while (!done_o && t < 60) begin
      if (!busy_o) busy_bad = 1'b1;
      @(negedge clk_i);
      t++;
    end
    check("busy_during_op", busy_bad, 0);
    if (!done_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no strobe after %0d cycles for a=%h b=%h", t, a, b);
      sb.delete();
    end else begin
      check("busy_during_done", busy_o, 1);
      @(negedge clk_i);
      check("busy_after_done", busy_o, 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_q"}, q_o, 0);
    check({tag, "_r"}, r_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_dbz"}, dbz_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    int saved_done;
    int ai, bi, mode;

    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases.
    run_div(16'h1234, 16'h0012);
    run_div(16'h9999, 16'h0001);
    run_div(16'h0007, 16'h0009);
    run_div(16'h5555, 16'h0000);
    run_div(16'h0000, 16'h0007);
    run_div(16'h9999, 16'h9999);

    // Randomised cases.
    for (int n = 0; n < 24; n++) begin
      ai = int'($urandom_range(0, 9999));
      mode = int'($urandom_range(0, 7));
      if (mode == 0) bi = 0;
      else if (mode == 1) bi = int'($urandom_range(1, 9));
      else if (mode == 2) bi = int'($urandom_range(1, 99));
      else bi = int'($urandom_range(1, 9999));
      run_div(int2bcd(ai), int2bcd(bi));
    end

    // Abort: a load during the operation is ignored, reset kills it silently.
    saved_done = n_done;
    a_i = 16'h9999;
    b_i = 16'h0001;
    ld_i = 1'b1;
    @(negedge clk_i);
    ld_i = 1'b0;
    repeat (4) @(negedge clk_i);
    a_i = 16'h0010;
    b_i = 16'h0002;
    ld_i = 1'b1;
    @(negedge clk_i);
    ld_i = 1'b0;
    repeat (13) @(negedge clk_i);
    check("busy_before_abort", busy_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_outputs_zero("abort");
    rst_ni = 1'b1;
    repeat (50) @(negedge clk_i);
    check("abort_no_done", n_done, saved_done);
    check("abort_idle", busy_o, 0);
    run_div(16'h0010, 16'h0002);

`ifdef BCD_DIV_DIGIT_CHK_EN
    run_div(16'h12A4, 16'h0003);
    run_div(16'h0010, 16'h000F);
`endif

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/bcd_div.md
# bcd_div

Sequential BCD divider: the inverse of the team's BCD multiply path. It accepts an N-digit packed-BCD dividend and divisor, and produces the packed-BCD quotient and remainder by digit-serial restoring division. Each trial subtraction takes one cycle. It sits beside the BCD add/sub/mul units in the decimal math library and is driven by the execute stage through a load/done handshake.

## Interface
- DIGITS, 4: number of BCD digits in each operand and result (width = 4*DIGITS)
- clk_i  in  1  clock, rising-edge
- rst_ni  in  1  reset, asynchronous, active-low
- ld_i  in  1  start request; sampled only in IDLE
- a_i  in  4*DIGITS  dividend, packed BCD
- b_i  in  4*DIGITS  divisor, packed BCD
- q_o  out  4*DIGITS  quotient
- r_o  out  4*DIGITS  remainder (always < divisor when valid)
- done_o  out  1  one-cycle result strobe
- busy_o  out  1  high whenever state != IDLE
- dbz_o  out  1  divide-by-zero flag, valid with done_o, held until next ld
- err_o  out  1  invalid-digit flag (see Configuration)

## Operation
- States: IDLE, SHIFT, SUB, DONE.
- IDLE, ld_i=1:
  - Capture a_i into the dividend shift register A, and b_i into B.
  - Clear R (DIGITS+1 digits), the quotient register Q, and the digit counter cnt.
  - Clear dbz_o and err_o.
  - If b_i==0: q_o=all 9s, r_o=a_i, dbz_o=1, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - R <= {R[DIGITS-1:0], A[MSD]}, then A <<= 4.
  - Go to SUB.
- SUB:
  - Form trial D = R - {0,B} with a (DIGITS+1)-digit ripple BCD subtract.
  - No borrow-out: R <= D, cnt <= cnt+1, stay in SUB.
  - Borrow-out: Q <= {Q[4*DIGITS-5:0], cnt}, cnt <= 0. If all DIGITS digits are done, go to DONE; otherwise go to SHIFT.
- DONE:
  - done_o=1 for exactly this cycle.
  - q_o=Q and r_o=R[DIGITS-1:0], updated on entry to DONE and held stable until the next accepted ld_i.
  - Go to IDLE.
- Arithmetic rules:
  - R < 10*B after each shift, so R fits in DIGITS+1 digits.
  - cnt never exceeds 9. A counter reaching 10 is a design error and is covered by an assertion.
- ld_i outside IDLE (including the DONE cycle) is ignored. There is no queueing.
- Reset mid-operation aborts immediately. All outputs return to 0 and the state to IDLE; no done_o is produced for the aborted operation.

## Timing
- Reset values: q_o=0, r_o=0, done_o=0, busy_o=0, dbz_o=0, err_o=0.
- Let edge 0 be the edge that samples ld_i.
  - Normal division: done_o is high during the cycle after edge Σ(q_k+2), summed over quotient digits q_k.
  - Minimum latency is 2*DIGITS; maximum is 11*DIGITS (44 for DIGITS=4).
  - Divide-by-zero and invalid-digit cases: done_o is high in the cycle after edge 1.
- busy_o rises in the cycle after edge 0 and falls in the cycle after DONE. The next ld_i is accepted one cycle after done_o.
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- BCD_DIV_DIGIT_CHK_EN defined:
  - At load, any nibble >9 in a_i or b_i forces DONE with err_o=1, q_o=0, r_o=0.
  - The digit check takes priority over divide-by-zero.
- BCD_DIV_DIGIT_CHK_EN undefined:
  - err_o is tied to 0 and no check logic is generated.
  - Non-BCD inputs produce deterministic but unspecified results; the latency bound still holds.

## Structure
- Package bcd_pkg holds:
  - DIGIT_W=4
  - the BCD_NINE constant
  - the state enum bcd_div_state_t (IDLE, SHIFT, SUB, DONE)
  - a function that checks whether a value is a valid BCD digit
- Sub-module bcd_sub_n (parameter N): combinational N-digit ripple BCD subtractor with borrow-in and borrow-out, instantiated once with N=DIGITS+1.
- The top level holds the FSM and the A, B, R, Q and cnt registers.

## Test plan
All scenarios use DIGITS=4.
- a=0x1234, b=0x0012 -> q=0x0102, r=0x0010, dbz=0, done in the cycle after edge 11.
- a=0x9999, b=0x0001 -> q=0x9999, r=0x0000, done in the cycle after edge 44; busy_o high throughout.
- a=0x0007, b=0x0009 -> q=0x0000, r=0x0007, done in the cycle after edge 8.
- a=0x5555, b=0x0000 -> dbz_o=1, q=0x9999, r=0x5555, done in the cycle after edge 1.
- Start a=0x9999, b=0x0001, then pulse ld_i with a=0x0010, b=0x0002 at cycle 5 and assert rst_ni=0 at cycle 20:
  - The second ld_i is ignored.
  - After reset, all outputs are 0 and no done_o is produced for the aborted operation.
  - A fresh ld with 0x0010/0x0002 returns q=0x0005, r=0.
- With BCD_DIV_DIGIT_CHK_EN defined: a=0x12A4, b=0x0003 -> err_o=1, q=0, r=0, done in the cycle after edge 1.
